keypad_scanner_p: RTL and testbench
===================================

KEYPAD_SCANNER_P -- requirements
Module: keypad_scanner_p

Interface
REQ-001 Parameter ROWS, default 4: number of keypad row inputs; legal range 2..8.
REQ-002 Parameter COLS, default 4: number of keypad column drives; legal range 2..8.
REQ-003 Parameter SCAN_DWELL, default 4: cycles each column is driven during scan; minimum 3.
REQ-004 Parameter DEBOUNCE_CYCLES, default 8: consecutive stable cycles needed to accept a press or release; minimum 2.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1: rising-edge clock.
REQ-007 nrst  input  1: asynchronous active-low reset.
REQ-008 row_d  input  ROWS: raw row sense, active high, asynchronous to clk.
REQ-009 col_q  output  COLS: one-hot column drive, active high.
REQ-010 key_code  output  $clog2(ROWS*COLS): last accepted key, row_index*COLS + col_index.
REQ-011 key_valid  output  1: one-cycle pulse when a key press is accepted.
REQ-012 key_release  output  1: one-cycle pulse when the held key's release is accepted.
REQ-013 key_held  output  1: high from key_valid until key_release, inclusive of key_release cycle.
REQ-014 multi_key  output  1: registered with key_valid; high if more than one row was active at acceptance.

Function
REQ-015 row_d SHALL pass through a 2-flop synchronizer; the result (row_s) is the only row value used internally.
REQ-016 States: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-017 SCAN: drive col_q = one-hot(col_idx); dwell counter counts 0..SCAN_DWELL-1; at count SCAN_DWELL-1, if row_s != 0 latch row_s as pattern and go DEBOUNCE (counter cleared), else increment col_idx and clear counter.
REQ-018 col_idx SHALL wrap from COLS-1 to 0.
REQ-019 DEBOUNCE: col_q held; each cycle row_s == pattern increments counter; any mismatch returns to SCAN with col_idx incremented.
REQ-020 When counter reaches DEBOUNCE_CYCLES-1 with a match, next cycle: key_valid=1, key_code updated, multi_key updated, key_held=1, state HELD.
REQ-021 Row index for key_code SHALL be the lowest set bit of pattern; multi_key=1 when pattern has two or more bits set.
REQ-022 HELD: col_q held; row_s changes other than to all-zero are ignored (no new key accepted, no rollover); row_s == 0 moves to RELEASE with counter cleared.
REQ-023 RELEASE: each cycle row_s == 0 increments counter; any nonzero row_s returns to HELD without any pulse.
REQ-024 When counter reaches DEBOUNCE_CYCLES-1 with row_s == 0, next cycle: key_release=1, key_held=0 the following cycle, state SCAN with col_idx incremented and dwell counter cleared.
REQ-025 key_code and multi_key SHALL hold their values until the next key_valid.
REQ-026 key_valid and key_release SHALL never assert in the same cycle, and each asserts for exactly one cycle.
REQ-027 Counters SHALL be sized to hold max(SCAN_DWELL, DEBOUNCE_CYCLES)-1 without overflow.

Reset
REQ-028 On nrst low, immediately: state SCAN, col_idx 0, col_q = one-hot bit 0, counters 0, synchronizer 0, key_code 0, key_valid 0, key_release 0, key_held 0, multi_key 0.
REQ-029 Reset asserted in any state, including mid-debounce or HELD, SHALL discard the press with no pulse emitted on deassertion.
REQ-030 After nrst deasserts, scanning begins on column 0 on the first rising edge.

Verification (defaults ROWS=4, COLS=4, SCAN_DWELL=4, DEBOUNCE_CYCLES=8)
REQ-031 Idle: row_d=0 for 40 cycles -> col_q cycles 0001,0010,0100,1000,0001 every 4 cycles; no pulses.
REQ-032 Press: row_d=0001 while col_q=0100, held 30 cycles -> single key_valid, key_code=2, multi_key=0, col_q stays 0100 while held; release held 12 cycles -> single key_release, scan resumes at 1000.
REQ-033 Bounce: row_d=1000 at col_q=0010 toggled to 0 after 3 cycles of DEBOUNCE -> no key_valid, scan advances to 0100; then stable row_d=1000 at col_q=0010 -> key_code=13.
REQ-034 Multi-key and rollover: row_d=0110 stable at col_q=0001 -> key_code=4, multi_key=1; while HELD change row_d to 0100 -> no new key_valid.
REQ-035 Release bounce: in RELEASE, row_d returns high after 3 zero cycles -> no key_release, key_held stays 1; later stable 0 -> one key_release.
REQ-036 Reset mid-operation: nrst low during DEBOUNCE and during HELD -> all outputs at reset values immediately, col_q=0001, no pulse after deassertion.

Source files
------------

// File: rtl/keypad_scanner_p_if.sv
// rtl/keypad_scanner_p_if.sv - keypad row sense / column drive / key report bundle
interface keypad_scanner_p_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
) ();
  localparam int KW = $clog2(ROWS * COLS);

  logic [ROWS-1:0] row_d;
  logic [COLS-1:0] col_q;
  logic [KW-1:0]   key_code;
  logic            key_valid;
  logic            key_release;
  logic            key_held;
  logic            multi_key;

  // scanner side
  modport master (
    input  row_d,
    output col_q, key_code, key_valid, key_release, key_held, multi_key
  );

  // keypad / consumer side
  modport slave (
    output row_d,
    input  col_q, key_code, key_valid, key_release, key_held, multi_key
  );
endinterface

// File: rtl/keypad_scanner_p.sv
// rtl/keypad_scanner_p.sv - column-scanning keypad reader with press/release debounce
module keypad_scanner_p #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DWELL      = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                nrst,
  keypad_scanner_p_if.master  kp
);
  localparam int KW   = $clog2(ROWS * COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int XW   = $clog2(COLS);
  localparam int CMAX = (SCAN_DWELL > DEBOUNCE_CYCLES) ? SCAN_DWELL : DEBOUNCE_CYCLES;
  localparam int CW   = $clog2(CMAX);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

  logic [ROWS-1:0] r_sync1, r_row_s, r_pattern, w_pattern;
  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [XW-1:0]   r_col, w_col, w_col_inc;
  logic [KW-1:0]   r_key_code, w_key_code;
  logic            r_key_valid, w_key_valid;
  logic            r_key_release, w_key_release;
  logic            r_key_held, w_key_held;
  logic            r_multi_key, w_multi_key;
  logic [RW-1:0]   w_row_idx;
  logic            w_multi;

  assign w_col_inc = (r_col == XW'(COLS - 1)) ? '0 : r_col + XW'(1);
  assign w_multi   = |(r_pattern & (r_pattern - ROWS'(1)));

  assign kp.col_q       = COLS'(1) << r_col;
  assign kp.key_code    = r_key_code;
  assign kp.key_valid   = r_key_valid;
  assign kp.key_release = r_key_release;
  assign kp.key_held    = r_key_held;
  assign kp.multi_key   = r_multi_key;

  // two-flop synchronizer; r_row_s is the only row view the FSM uses
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sync1 <= '0;
      r_row_s <= '0;
    end else begin
      r_sync1 <= kp.row_d;
      r_row_s <= r_sync1;
    end
  end

  // lowest set row of the latched pattern picks the reported row
  always_comb begin
    w_row_idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (r_pattern[i]) w_row_idx = RW'(i);
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state       <= S_SCAN;
      r_cnt         <= '0;
      r_col         <= '0;
      r_pattern     <= '0;
      r_key_code    <= '0;
      r_key_valid   <= 1'b0;
      r_key_release <= 1'b0;
      r_key_held    <= 1'b0;
      r_multi_key   <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_col         <= w_col;
      r_pattern     <= w_pattern;
      r_key_code    <= w_key_code;
      r_key_valid   <= w_key_valid;
      r_key_release <= w_key_release;
      r_key_held    <= w_key_held;
      r_multi_key   <= w_multi_key;
    end
  end

  // next-state: scan columns, debounce press, hold, debounce release
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_col         = r_col;
    w_pattern     = r_pattern;
    w_key_code    = r_key_code;
    w_multi_key   = r_multi_key;
    w_key_valid   = 1'b0;
    w_key_release = 1'b0;
    // key_held stays up through the release pulse and drops one cycle later
    w_key_held    = r_key_release ? 1'b0 : r_key_held;
    case (r_state)
      S_SCAN: begin
        if (r_cnt == CW'(SCAN_DWELL - 1)) begin
          w_cnt = '0;
          if (r_row_s != '0) begin
            w_pattern = r_row_s;
            w_state   = S_DEBOUNCE;
          end else begin
            w_col = w_col_inc;
          end
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_DEBOUNCE: begin
        if (r_row_s != r_pattern) begin
          w_state = S_SCAN;
          w_cnt   = '0;
          w_col   = w_col_inc;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          w_state     = S_HELD;
          w_cnt       = '0;
          w_key_valid = 1'b1;
          w_key_held  = 1'b1;
          w_key_code  = KW'(int'(w_row_idx) * COLS + int'(r_col));
          w_multi_key = w_multi;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_HELD: begin
        // any nonzero change is ignored: no rollover while a key is held
        if (r_row_s == '0) begin
          w_state = S_RELEASE;
          w_cnt   = '0;
        end
      end
      S_RELEASE: begin
        if (r_row_s != '0) begin
          w_state = S_HELD;
          w_cnt   = '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          w_state       = S_SCAN;
          w_cnt         = '0;
          w_col         = w_col_inc;
          w_key_release = 1'b1;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state = S_SCAN;
        w_cnt   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_keypad_scanner_p.sv
// tb/tb_keypad_scanner_p.sv - directed self-checking bench for keypad_scanner_p
module tb_keypad_scanner_p;
  logic clk = 1'b0;
  logic nrst = 1'b0;

  keypad_scanner_p_if #(.ROWS(4), .COLS(4)) kp ();

  keypad_scanner_p #(
    .ROWS(4), .COLS(4), .SCAN_DWELL(4), .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .kp   (kp)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int n_valid = 0;
  int n_rel   = 0;
  int n_both  = 0;
  int v0, r0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock, sampled 1 time unit after the rising edge; tallies pulses
  task automatic tick();
    @(posedge clk);
    #1;
    if (kp.key_valid) n_valid++;
    if (kp.key_release) n_rel++;
    if (kp.key_valid && kp.key_release) n_both++;
    if (kp.key_release) check("held_at_release", 32'(kp.key_held), 32'd1);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // advance to the first cycle of the given column
  task automatic wait_col(input logic [3:0] target);
    logic prev;
    bit   hit;
    prev = (kp.col_q == target);
    hit  = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      if (kp.col_q == target && !prev) hit = 1'b1;
      prev = (kp.col_q == target);
    end
    if (!hit) check("wait_col_timeout", 32'(kp.col_q), 32'(target));
  endtask

  initial begin
    logic [3:0] one;
    one = 4'b0001;
    kp.row_d = '0;

    // reset state
    @(posedge clk);
    #1;
    check("rst_col_q", 32'(kp.col_q), 32'h1);
    check("rst_key_code", 32'(kp.key_code), 32'h0);
    check("rst_key_valid", 32'(kp.key_valid), 32'h0);
    check("rst_key_release", 32'(kp.key_release), 32'h0);
    check("rst_key_held", 32'(kp.key_held), 32'h0);
    check("rst_multi_key", 32'(kp.multi_key), 32'h0);
    nrst = 1'b1;

    // idle scan: column advances every 4 cycles, wraps after the last
    v0 = n_valid; r0 = n_rel;
    for (int k = 1; k <= 40; k++) begin
      tick();
      check($sformatf("idle_col_%0d", k), 32'(kp.col_q), 32'(one << ((k / 4) % 4)));
    end
    check("idle_no_valid", n_valid - v0, 0);
    check("idle_no_release", n_rel - r0, 0);

    // press row 0 on column 2
    wait_col(4'b0100);
    v0 = n_valid; r0 = n_rel;
    kp.row_d = 4'b0001;
    for (int k = 0; k < 30; k++) begin
      tick();
      check("press_col_hold", 32'(kp.col_q), 32'h4);
    end
    check("press_one_valid", n_valid - v0, 1);
    check("press_code", 32'(kp.key_code), 32'd2);
    check("press_multi", 32'(kp.multi_key), 32'd0);
    check("press_held", 32'(kp.key_held), 32'd1);
    kp.row_d = 4'b0000;
    run(12);
    check("rel_one_release", n_rel - r0, 1);
    check("rel_no_valid", n_valid - v0, 1);
    check("rel_held_low", 32'(kp.key_held), 32'd0);
    check("rel_resume_col", 32'(kp.col_q), 32'h8);
    check("rel_code_kept", 32'(kp.key_code), 32'd2);

    // press bounce on column 1: three matching debounce cycles then drop
    wait_col(4'b0010);
    v0 = n_valid;
    kp.row_d = 4'b1000;
    run(5);
    kp.row_d = 4'b0000;
    run(3);
    check("bounce_col_adv", 32'(kp.col_q), 32'h4);
    check("bounce_no_valid", n_valid - v0, 0);
    check("bounce_not_held", 32'(kp.key_held), 32'd0);

    // stable row 3 on column 1 -> code 13
    wait_col(4'b0010);
    v0 = n_valid; r0 = n_rel;
    kp.row_d = 4'b1000;
    run(20);
    check("r3c1_valid", n_valid - v0, 1);
    check("r3c1_code", 32'(kp.key_code), 32'd13);
    check("r3c1_multi", 32'(kp.multi_key), 32'd0);
    kp.row_d = 4'b0000;
    run(12);
    check("r3c1_release", n_rel - r0, 1);

    // two rows on column 0 -> lowest row wins, multi flagged; no rollover
    wait_col(4'b0001);
    v0 = n_valid; r0 = n_rel;
    kp.row_d = 4'b0110;
    run(14);
    check("multi_valid", n_valid - v0, 1);
    check("multi_code", 32'(kp.key_code), 32'd4);
    check("multi_flag", 32'(kp.multi_key), 32'd1);
    kp.row_d = 4'b0100;
    run(15);
    check("rollover_no_valid", n_valid - v0, 1);
    check("rollover_code", 32'(kp.key_code), 32'd4);
    check("rollover_multi", 32'(kp.multi_key), 32'd1);
    check("rollover_held", 32'(kp.key_held), 32'd1);
    check("rollover_col", 32'(kp.col_q), 32'h1);

    // release bounce: three zero cycles in RELEASE, then rows come back
    kp.row_d = 4'b0000;
    run(4);
    kp.row_d = 4'b0100;
    run(8);
    check("relbounce_no_release", n_rel - r0, 0);
    check("relbounce_held", 32'(kp.key_held), 32'd1);
    kp.row_d = 4'b0000;
    run(12);
    check("relbounce_one_release", n_rel - r0, 1);
    check("relbounce_held_low", 32'(kp.key_held), 32'd0);

    // reset during press debounce
    wait_col(4'b0001);
    v0 = n_valid; r0 = n_rel;
    kp.row_d = 4'b0001;
    run(6);
    nrst = 1'b0;
    #1;
    check("rstdb_col_q", 32'(kp.col_q), 32'h1);
    check("rstdb_code", 32'(kp.key_code), 32'h0);
    check("rstdb_multi", 32'(kp.multi_key), 32'h0);
    check("rstdb_valid", 32'(kp.key_valid), 32'h0);
    kp.row_d = 4'b0000;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    run(20);
    check("rstdb_no_valid", n_valid - v0, 0);
    check("rstdb_no_release", n_rel - r0, 0);

    // reset while held with row 3 on column 0 (code 12)
    wait_col(4'b0001);
    v0 = n_valid;
    kp.row_d = 4'b1000;
    run(20);
    check("held_valid", n_valid - v0, 1);
    check("held_code", 32'(kp.key_code), 32'd12);
    check("held_high", 32'(kp.key_held), 32'd1);
    nrst = 1'b0;
    #1;
    check("rsth_held", 32'(kp.key_held), 32'h0);
    check("rsth_code", 32'(kp.key_code), 32'h0);
    check("rsth_col_q", 32'(kp.col_q), 32'h1);
    check("rsth_release", 32'(kp.key_release), 32'h0);
    kp.row_d = 4'b0000;
    v0 = n_valid; r0 = n_rel;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    run(20);
    check("rsth_no_valid", n_valid - v0, 0);
    check("rsth_no_release", n_rel - r0, 0);
    check("rsth_held_low", 32'(kp.key_held), 32'h0);

    check("never_both", n_both, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
